// File: rtl/uart_frame_pkg.sv
// ---------------------------------------------------------------------------
// uart_frame_pkg
//
// Shared definitions for the UART frame reader:
//   SOF_BYTE         start-of-frame marker that the hunter looks for
//   DEFAULT_MAX_LEN  default payload capacity of the frame buffer
//   state_t          frame reader FSM encoding
//   sat_inc8()       saturating 8-bit increment used by the error counter
// ---------------------------------------------------------------------------
package uart_frame_pkg;

    localparam logic [7:0] SOF_BYTE        = 8'hA5;
    localparam int         DEFAULT_MAX_LEN = 8;

    // HUNT     : discard bytes until SOF_BYTE is seen
    // TYPE     : next byte is the frame type
    // LEN      : next byte is the payload length
    // PAYLOAD  : LEN payload bytes are written to the buffer
    // CHK      : next byte is compared with the running XOR
    // HOLD     : a good frame is presented; the FIFO is left untouched
    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_TYPE    = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHK     = 3'd4,
        ST_HOLD    = 3'd5
    } state_t;

    // Counters that report "how many things went wrong" must not wrap,
    // otherwise a burst of 256 errors would read as zero.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/frame_buf.sv
// ---------------------------------------------------------------------------
// frame_buf
//
// Payload storage for the frame reader: MAX_LEN entries of 8 bits with one
// synchronous write port and one combinational read port. The contents are
// intentionally not reset; only entries below the held frame length carry
// meaning.
//
// Ports:
//   clk    in   system clock
//   we     in   write enable, sampled on the rising edge
//   waddr  in   write address (AW bits)
//   wdata  in   write data byte
//   raddr  in   read address (AW bits)
//   rdata  out  byte stored at raddr, combinational; 0 for addresses
//               beyond the array when 2^AW > MAX_LEN
// ---------------------------------------------------------------------------
module frame_buf
    import uart_frame_pkg::*;
#(
    parameter int MAX_LEN = DEFAULT_MAX_LEN,
    parameter int AW      = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem_q [MAX_LEN];

    // Writes outside the physical array are ignored so a non power-of-two
    // MAX_LEN can never corrupt neighbouring storage.
    always_ff @(posedge clk) begin
        if (we && (32'(waddr) < MAX_LEN)) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata = 8'h00;
        if (32'(raddr) < MAX_LEN) begin
            rdata = mem_q[raddr];
        end
    end

endmodule

// File: rtl/uart_frame_reader.sv
// ---------------------------------------------------------------------------
// uart_frame_reader
//
// Pops bytes from the UART receive FIFO, hunts for the start-of-frame byte
// and assembles SOF / TYPE / LEN / payload / CHK frames. CHK is the XOR of
// TYPE, LEN and every payload byte. A checksum-good frame is held on
// frame_valid until the consumer acknowledges it; while it is held no bytes
// are popped, so the UART FIFO itself provides backpressure. Oversized
// lengths and bad checksums drop the frame with a one-cycle err_pulse and a
// saturating err_count.
//
// Optional feature (compile-time macro UART_FRAME_TIMEOUT_EN):
//   when defined, an inter-byte counter runs while a frame is partially
//   received and drops the frame as an error after TIMEOUT_CYCLES cycles
//   without a byte. When undefined, no counter exists and a partial frame
//   waits indefinitely.
//
// Parameters:
//   MAX_LEN         maximum payload bytes (1..255)
//   AW              payload buffer address width, 2^AW >= MAX_LEN
//   TIMEOUT_CYCLES  inter-byte timeout in clk cycles (timeout build only)
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   rx_empty     in   UART receive FIFO empty
//   r_data       in   UART receive FIFO head byte, valid when rx_empty=0
//   rd_uart      out  pop strobe to the UART receive FIFO
//   frame_valid  out  a complete, checksum-good frame is held
//   frame_type   out  TYPE byte of the held frame
//   frame_len    out  LEN byte of the held frame
//   rd_addr      in   payload read address
//   rd_data      out  payload byte at rd_addr, combinational
//   frame_ack    in   consumer releases the held frame
//   err_pulse    out  one-cycle pulse when a frame is dropped
//   err_count    out  saturating count of dropped frames
// ---------------------------------------------------------------------------
module uart_frame_reader
    import uart_frame_pkg::*;
#(
    parameter int MAX_LEN        = DEFAULT_MAX_LEN,
    parameter int AW             = 3,
    parameter int TIMEOUT_CYCLES = 75000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx_empty,
    input  logic [7:0]    r_data,
    output logic          rd_uart,
    output logic          frame_valid,
    output logic [7:0]    frame_type,
    output logic [7:0]    frame_len,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    input  logic          frame_ack,
    output logic          err_pulse,
    output logic [7:0]    err_count
);

    // Refuse to elaborate with a buffer that cannot hold MAX_LEN bytes or
    // with a length limit that the 8-bit LEN field cannot express.
    if (MAX_LEN < 1 || MAX_LEN > 255 || (2 ** AW) < MAX_LEN || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("uart_frame_reader: illegal MAX_LEN / AW / TIMEOUT_CYCLES combination");
    end

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t     state_q,     state_d;
    logic [7:0] type_q,      type_d;
    logic [7:0] len_q,       len_d;
    logic [7:0] chk_q,       chk_d;
    logic [7:0] idx_q,       idx_d;
    logic [7:0] err_count_q, err_count_d;
    logic       err_pulse_q, err_pulse_d;

    logic       pop;
    logic       buf_we;
    logic       drop;
    logic       timeout;

    // A byte is consumed on every edge where the strobe is high, so the
    // strobe doubles as the "byte available this cycle" qualifier for the
    // FSM. HOLD is the only state that refuses bytes.
    assign pop     = ~rx_empty & (state_q != ST_HOLD);
    assign rd_uart = pop;

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int             TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] timer_q, timer_d;

    // The counter only runs while a frame is partially received. Each
    // consumed byte restarts it; reaching the limit on an idle cycle means
    // TIMEOUT_CYCLES cycles have passed without a byte.
    always_comb begin
        timer_d = '0;
        timeout = 1'b0;
        case (state_q)
            ST_TYPE, ST_LEN, ST_PAYLOAD, ST_CHK: begin
                if (pop) begin
                    timer_d = '0;
                end else if (timer_q == TIMER_LAST) begin
                    timeout = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Next-state logic. Once past HUNT every byte is treated as data, so an
    // SOF value inside a frame never resynchronises the decoder; only an
    // error (or reset) sends it back to hunting.
    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        len_d       = len_q;
        chk_d       = chk_q;
        idx_d       = idx_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;
        buf_we      = 1'b0;
        drop        = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (pop && (r_data == SOF_BYTE)) begin
                    state_d = ST_TYPE;
                end
            end

            ST_TYPE: begin
                if (pop) begin
                    type_d  = r_data;
                    chk_d   = r_data;
                    state_d = ST_LEN;
                end
            end

            ST_LEN: begin
                if (pop) begin
                    if (r_data > MAX_LEN_B) begin
                        drop = 1'b1;
                    end else begin
                        len_d   = r_data;
                        chk_d   = chk_q ^ r_data;
                        idx_d   = 8'd0;
                        state_d = (r_data == 8'd0) ? ST_CHK : ST_PAYLOAD;
                    end
                end
            end

            ST_PAYLOAD: begin
                if (pop) begin
                    buf_we = 1'b1;
                    chk_d  = chk_q ^ r_data;
                    idx_d  = idx_q + 8'd1;
                    if (idx_q == (len_q - 8'd1)) begin
                        state_d = ST_CHK;
                    end
                end
            end

            ST_CHK: begin
                if (pop) begin
                    if (r_data == chk_q) begin
                        state_d = ST_HOLD;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end

            ST_HOLD: begin
                if (frame_ack) begin
                    state_d = ST_HUNT;
                end
            end

            default: begin
                state_d = ST_HUNT;
            end
        endcase

        // Every kind of drop is reported the same way and restarts hunting.
        if (timeout) begin
            drop = 1'b1;
        end
        if (drop) begin
            state_d     = ST_HUNT;
            err_pulse_d = 1'b1;
            err_count_d = sat_inc8(err_count_q);
        end
    end

    // State registers. A reset abandons a partial or held frame without
    // counting it as an error.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_HUNT;
            type_q      <= 8'h00;
            len_q       <= 8'h00;
            chk_q       <= 8'h00;
            idx_q       <= 8'h00;
            err_pulse_q <= 1'b0;
            err_count_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            len_q       <= len_d;
            chk_q       <= chk_d;
            idx_q       <= idx_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    // The payload index never reaches MAX_LEN while writing, so its low AW
    // bits address the buffer directly.
    frame_buf #(
        .MAX_LEN (MAX_LEN),
        .AW      (AW)
    ) u_frame_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (idx_q[AW-1:0]),
        .wdata (r_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign frame_valid = (state_q == ST_HOLD);
    assign frame_type  = type_q;
    assign frame_len   = len_q;
    assign err_pulse   = err_pulse_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_uart_frame_reader.sv
// ---------------------------------------------------------------------------
// tb_uart_frame_reader
//
// Directed bench for uart_frame_reader. A byte queue stands in for the UART
// receive FIFO; every frame or dropped frame that is queued also pushes its
// expected outcome onto a scoreboard, which is popped when the reader
// presents a frame or pulses an error. Build with UART_FRAME_TIMEOUT_EN to
// also exercise the inter-byte timeout (TIMEOUT_CYCLES = 100 here).
// ---------------------------------------------------------------------------
module tb_uart_frame_reader;

    localparam int         MAX_LEN  = 8;
    localparam int         AW       = 3;
    localparam int         TIMEOUT  = 100;
    localparam logic [7:0] SOF      = 8'hA5;

    typedef struct {
        bit         good;
        logic [7:0] typ;
        logic [7:0] len;
        logic [7:0] pl [8];
    } exp_t;

    logic          clk;
    logic          reset;
    logic          rx_empty;
    logic [7:0]    r_data;
    logic          rd_uart;
    logic          frame_valid;
    logic [7:0]    frame_type;
    logic [7:0]    frame_len;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          frame_ack;
    logic          err_pulse;
    logic [7:0]    err_count;

    logic [7:0] fifo [$];
    exp_t       sb [$];
    int         checks;
    int         failures;
    int         err_model;
    logic [7:0] last_typ;

    uart_frame_reader #(
        .MAX_LEN        (MAX_LEN),
        .AW             (AW),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_empty    (rx_empty),
        .r_data      (r_data),
        .rd_uart     (rd_uart),
        .frame_valid (frame_valid),
        .frame_type  (frame_type),
        .frame_len   (frame_len),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_ack   (frame_ack),
        .err_pulse   (err_pulse),
        .err_count   (err_count)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Presents the head of the byte queue to the reader.
    task automatic refresh();
        rx_empty = (fifo.size() == 0);
        r_data   = rx_empty ? 8'h00 : fifo[0];
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        fifo.push_back(b);
        refresh();
    endtask

    task automatic pushExpErr();
        exp_t e;
        e.good = 1'b0;
        e.typ  = 8'h00;
        e.len  = 8'h00;
        for (int i = 0; i < 8; i++) e.pl[i] = 8'h00;
        sb.push_back(e);
    endtask

    task automatic sendFrame(input logic [7:0] typ, input logic [7:0] len, input logic [7:0] pl [8]);
        exp_t       e;
        logic [7:0] chk;
        applyStimulus(SOF);
        applyStimulus(typ);
        applyStimulus(len);
        chk = typ ^ len;
        for (int i = 0; i < int'(len); i++) begin
            applyStimulus(pl[i]);
            chk = chk ^ pl[i];
        end
        applyStimulus(chk);
        e.good = 1'b1;
        e.typ  = typ;
        e.len  = len;
        e.pl   = pl;
        sb.push_back(e);
    endtask

    // One clock cycle: the strobe seen just before the edge decides whether
    // the queue head was consumed. Any error pulse is matched against the
    // scoreboard and the saturating error count.
    task automatic tick();
        logic p;
        exp_t e;
        #1;
        p = rd_uart;
        @(posedge clk);
        #1;
        if (p && fifo.size() != 0) void'(fifo.pop_front());
        refresh();
        #1;
        if (err_pulse === 1'b1) begin
            if (sb.size() == 0) e.good = 1'b1;
            else e = sb.pop_front();
            checkOutput("err_expected", {31'b0, e.good}, 32'd0);
            err_model = (err_model >= 255) ? 255 : err_model + 1;
            checkOutput("err_count", {24'b0, err_count}, err_model);
        end
    endtask

    task automatic waitForFrame(input int budget);
        int   n;
        exp_t e;
        n = 0;
        while (frame_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        checkOutput("frame_wait", {31'b0, frame_valid}, 32'd1);
        if (frame_valid === 1'b1) begin
            if (sb.size() == 0) e.good = 1'b0;
            else e = sb.pop_front();
            checkOutput("frame_expected", {31'b0, e.good}, 32'd1);
            if (e.good) begin
                last_typ = e.typ;
                checkOutput("frame_type", {24'b0, frame_type}, {24'b0, e.typ});
                checkOutput("frame_len", {24'b0, frame_len}, {24'b0, e.len});
                for (int i = 0; i < int'(e.len) && i < MAX_LEN; i++) begin
                    rd_addr = AW'(i);
                    #1;
                    checkOutput($sformatf("payload[%0d]", i), {24'b0, rd_data}, {24'b0, e.pl[i]});
                end
            end
        end
    endtask

    task automatic ackFrame(input int delay);
        for (int i = 0; i < delay; i++) begin
            tick();
            checkOutput("hold_rd_uart", {31'b0, rd_uart}, 32'd0);
            checkOutput("hold_valid", {31'b0, frame_valid}, 32'd1);
        end
        checkOutput("hold_type_stable", {24'b0, frame_type}, {24'b0, last_typ});
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        checkOutput("ack_valid", {31'b0, frame_valid}, 32'd0);
    endtask

    initial begin
        logic [7:0] pl [8];
        int         n;
        int         depth;

        checks    = 0;
        failures  = 0;
        err_model = 0;
        last_typ  = 8'h00;
        reset     = 1'b1;
        frame_ack = 1'b0;
        rd_addr   = '0;
        refresh();
        tick();
        tick();
        reset = 1'b0;
        tick();

        $display("[TB] reset values");
        checkOutput("reset_valid", {31'b0, frame_valid}, 32'd0);
        checkOutput("reset_type", {24'b0, frame_type}, 32'd0);
        checkOutput("reset_len", {24'b0, frame_len}, 32'd0);
        checkOutput("reset_err_pulse", {31'b0, err_pulse}, 32'd0);
        checkOutput("reset_err_count", {24'b0, err_count}, 32'd0);
        checkOutput("reset_rd_uart", {31'b0, rd_uart}, 32'd0);

        $display("[TB] clean frame");
        pl = '{8'h10, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        sendFrame(8'h01, 8'd2, pl);
        waitForFrame(40);
        ackFrame(0);
        checkOutput("clean_err_count", {24'b0, err_count}, 32'd0);

        $display("[TB] reset during payload");
        applyStimulus(SOF);
        applyStimulus(8'h05);
        applyStimulus(8'h03);
        applyStimulus(8'h11);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        err_model = 0;
        checkOutput("midreset_valid", {31'b0, frame_valid}, 32'd0);
        checkOutput("midreset_err_count", {24'b0, err_count}, 32'd0);
        checkOutput("midreset_type", {24'b0, frame_type}, 32'd0);

        $display("[TB] garbage then zero-length frame");
        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        pl = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        sendFrame(8'h07, 8'd0, pl);
        waitForFrame(40);
        ackFrame(2);
        checkOutput("garbage_err_count", {24'b0, err_count}, 32'd0);

        $display("[TB] bad checksum then good frame");
        applyStimulus(SOF);
        applyStimulus(8'h01);
        applyStimulus(8'h01);
        applyStimulus(8'h55);
        applyStimulus(8'h00);
        pushExpErr();
        pl = '{8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        sendFrame(8'h02, 8'd1, pl);
        waitForFrame(40);
        checkOutput("badchk_err_count", {24'b0, err_count}, 32'd1);
        ackFrame(0);

        $display("[TB] oversize length");
        applyStimulus(SOF);
        applyStimulus(8'h01);
        applyStimulus(8'h09);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        pushExpErr();
        pl = '{8'h44, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        sendFrame(8'h03, 8'd1, pl);
        waitForFrame(40);
        checkOutput("oversize_err_count", {24'b0, err_count}, 32'd2);
        ackFrame(0);

        $display("[TB] full-length frame with SOF values as data");
        pl = '{8'hA5, 8'h00, 8'hFF, 8'h5A, 8'h01, 8'h80, 8'hA5, 8'h7E};
        sendFrame(8'hA5, 8'd8, pl);
        waitForFrame(40);
        ackFrame(1);

        $display("[TB] backpressure with two queued frames");
        pl = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        sendFrame(8'h10, 8'd3, pl);
        pl = '{8'h9A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        sendFrame(8'h11, 8'd1, pl);
        waitForFrame(40);
        depth = fifo.size();
        checkOutput("bp_depth_at_hold", depth, 32'd5);
        ackFrame(20);
        checkOutput("bp_depth_after_ack", fifo.size(), 32'd5);
        waitForFrame(40);
        ackFrame(0);

        $display("[TB] error counter saturation");
        repeat (256) begin
            applyStimulus(SOF);
            applyStimulus(8'h01);
            applyStimulus(8'h09);
            pushExpErr();
        end
        n = 0;
        while (fifo.size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        tick();
        tick();
        checkOutput("sat_drained", fifo.size(), 32'd0);
        checkOutput("sat_err_count", {24'b0, err_count}, 32'd255);

        $display("[TB] reset drops a held frame");
        pl = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        sendFrame(8'h20, 8'd1, pl);
        waitForFrame(40);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        err_model = 0;
        checkOutput("holdreset_valid", {31'b0, frame_valid}, 32'd0);
        checkOutput("holdreset_err_count", {24'b0, err_count}, 32'd0);
        checkOutput("holdreset_len", {24'b0, frame_len}, 32'd0);

`ifdef UART_FRAME_TIMEOUT_EN
        $display("[TB] inter-byte timeout");
        applyStimulus(SOF);
        applyStimulus(8'h01);
        pushExpErr();
        tick();
        tick();
        n = 0;
        while (err_pulse !== 1'b1 && n < 300) begin
            n++;
            tick();
        end
        checkOutput("timeout_cycles", n, TIMEOUT);
        checkOutput("timeout_err_count", {24'b0, err_count}, 32'd1);
`endif

        checkOutput("scoreboard_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
